// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings shared by the multiply/divide unit and the decoder
package muldiv_pkg;
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIX  = 2'b10
    } state_t;
endpackage

// File: rtl/muldiv_abs.sv
// muldiv_abs: conditional two's-complement negate
module muldiv_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);
    assign out = neg ? -in : in;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide owning the HI/LO pair
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import muldiv_pkg::*;
    localparam int CW = $clog2(WIDTH) + 1;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic div_r, sa, sb, sg;
    logic [WIDTH-1:0] ma, mb, a_mag, b_mag, q_fix, r_fix, rem;
    logic [2*WIDTH-1:0] acc, acc_n, p_fix;
    logic [WIDTH:0] sum, t;
    logic qb;
    assign sg = (op == OP_MULT) || (op == OP_DIV);
    assign busy = state != ST_IDLE;
    muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (.in(a), .neg(sg & a[WIDTH-1]), .out(a_mag));
    muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (.in(b), .neg(sg & b[WIDTH-1]), .out(b_mag));
    muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_p (.in(acc), .neg(sa ^ sb), .out(p_fix));
    muldiv_abs #(.WIDTH(WIDTH)) u_fix_q (.in(acc[WIDTH-1:0]), .neg(sa ^ sb), .out(q_fix));
    muldiv_abs #(.WIDTH(WIDTH)) u_fix_r (.in(acc[2*WIDTH-1:WIDTH]), .neg(sa), .out(r_fix));
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = (state == ST_IDLE) ? (start ? ST_ITER : ST_IDLE) :
                  (state == ST_ITER) ? ((cnt == CW'(WIDTH - 1)) ? ST_FIX : ST_ITER) : ST_IDLE;
    end
    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? ma : '0};
        t = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        qb = t >= {1'b0, mb};
        rem = qb ? WIDTH'(t - {1'b0, mb}) : t[WIDTH-1:0];
        acc_n = div_r ? {rem, acc[WIDTH-2:0], qb} : {sum, acc[WIDTH-1:1]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
            done <= 1'b0;
            dbz <= 1'b0;
            cnt <= '0;
        end else begin
            done <= state == ST_FIX;
            if (state == ST_IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
                if (start) begin
                    div_r <= op[1];
                    sa <= sg & a[WIDTH-1];
                    sb <= sg & b[WIDTH-1];
                    ma <= a_mag;
                    mb <= b_mag;
                    acc <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                    cnt <= '0;
                    dbz <= 1'b0;
                end
            end
            if (state == ST_ITER) begin
                acc <= acc_n;
                cnt <= cnt + 1'b1;
            end
            // A zero divisor leaves the remainder equal to |a|, so hi already restores a.
            if (state == ST_FIX) begin
                if (div_r) begin
                    hi <= r_fix;
                    lo <= (mb == '0) ? '1 : q_fix;
                    dbz <= mb == '0;
                end else begin
                    {hi, lo} <= p_fix;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table, corner sequences and random ops against an arithmetic model
module tb_muldiv_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, start, hi_we, lo_we;
    logic [1:0] op;
    logic [31:0] a, b, wdata, hi, lo;
    logic busy, done, dbz;
    logic start8;
    logic [1:0] op8;
    logic [7:0] a8, b8, hi8, lo8;
    logic busy8, done8, dbz8;
    int pass_n = 0, total = 0;
    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
    );
    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
        .busy(busy8), .done(done8), .dbz(dbz8), .hi(hi8), .lo(lo8)
    );
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
    } vec_t;
    vec_t vt[8];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        if (o[1] && y == 0) return {x, 32'hFFFFFFFF};
        case (o)
            2'd0: return ux * uy;
            2'd1: return sx * sy;
            2'd2: return {32'(ux % uy), 32'(ux / uy)};
            default: return {32'(sx % sy), 32'(sx / sy)};
        endcase
    endfunction
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask
    task automatic wait_done(output int lat, output logic busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            busy_ok &= busy;
            @(posedge clk); #1;
            lat++;
        end
        busy_ok &= !busy;
    endtask
    task automatic go8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output int lat);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask
    initial begin
        int lat, n;
        logic bok;
        logic [1:0] ro;
        logic [31:0] ra, rb;
        vt[0] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[1] = '{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vt[2] = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[3] = '{2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        vt[4] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vt[5] = '{2'd0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
        vt[6] = '{2'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vt[7] = '{2'd2, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'd0; a = '0; b = '0; wdata = '0;
        start8 = 1'b0; op8 = 2'd0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", {busy, done, dbz, hi, lo}, '0);
        // Each start after the first lands in the previous done cycle.
        for (int i = 0; i < 8; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b);
            wait_done(lat, bok);
            chk($sformatf("vec%0d_latency", i), lat, 33);
            chk($sformatf("vec%0d_busy", i), bok, 1);
            chk($sformatf("vec%0d_hilo", i), {hi, lo}, {vt[i].hi, vt[i].lo});
            chk($sformatf("vec%0d_dbz", i), dbz, vt[i].dbz);
        end
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        repeat (3) @(posedge clk); #1;
        chk("dbz_sticky", dbz, 1);
        issue(2'd0, 32'd3, 32'd5);
        chk("dbz_clear_on_accept", dbz, 0);
        wait_done(lat, bok);
        chk("mul_3x5", {hi, lo}, 64'd15);
        issue(2'd0, 32'h00010000, 32'h00010001);
        repeat (5) @(posedge clk);
        op = 2'd2; a = 32'd1; b = 32'd1; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        wait_done(lat, bok);
        chk("busy_ignore_latency", lat + 6, 33);
        chk("busy_ignore_hilo", {hi, lo}, 64'h00000001_00010000);
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        chk("no_extra_done", n, 0);
        hi_we = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        hi_we = 1'b0;
        chk("mthi_idle", {hi, lo}, 64'h0000DEAD_00010000);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hBEEF;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi_mtlo_both", {hi, lo}, 64'h0000BEEF_0000BEEF);
        issue(2'd0, 32'hFFFFFFFF, 32'd2);
        repeat (10) @(posedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_reset", {busy, done, hi, lo}, '0);
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        chk("abort_no_done", {n, hi, lo}, '0);
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(3));
            ra = ($urandom_range(7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(7))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                2: rb = $urandom_range(15);
                default: rb = $urandom;
            endcase
            issue(ro, ra, rb);
            wait_done(lat, bok);
            chk($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), {hi, lo}, model(ro, ra, rb));
            chk($sformatf("rand%0d_dbz", i), dbz, ro[1] && rb == 0);
            chk($sformatf("rand%0d_latency", i), lat, 33);
            repeat ($urandom_range(2)) @(posedge clk);
            #0;
        end
        go8(2'd1, 8'h80, 8'h80, lat);
        chk("w8_mult_latency", lat, 9);
        chk("w8_mult_hilo", {hi8, lo8}, 16'h4000);
        go8(2'd3, 8'h80, 8'h03, lat);
        chk("w8_div_hilo", {hi8, lo8, dbz8}, {16'hFED6, 1'b0});
        chk("w8_div_busy", busy8, 0);
        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end
endmodule
